// File: rtl/hfrv_uart_pkg.sv
// Shared types and helpers for the hfrv UART blocks.
package hfrv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Width of a down-counter that has to hold values up to clk_div-1.
  function automatic int uart_cnt_w(input int clk_div);
    return (clk_div < 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/hfrv_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and drop flag.
module hfrv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             pop_fire;
  logic             push_ok;

  assign valid    = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_fire = pop && valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push && (!full || pop_fire);
  assign drop     = push && !push_ok;
  assign dout     = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hfrv_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, framing-error
// detection and a FWFT output FIFO with valid/ready.
module hfrv_uart_rx
  import hfrv_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_tx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int            CW      = uart_cnt_w(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_IX = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state, state_nxt;

  logic                      sync_p0;
  logic                      rxs_p1;
  logic                      rxs_prev_p2;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_val;
  logic                      cnt_load;
  logic                      expired;
  logic [2:0]                bit_idx;
  logic                      idx_clr;
  logic                      shift_en;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      byte_done;
  logic                      stop_bad;
  logic                      fifo_drop;

  // Synchronizer stages; the delayed copy feeds start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0     <= 1'b1;
      rxs_p1      <= 1'b1;
      rxs_prev_p2 <= 1'b1;
    end else begin
      sync_p0     <= uart_tx;
      rxs_p1      <= sync_p0;
      rxs_prev_p2 <= rxs_p1;
    end
  end

  assign expired = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = FULL_M1;
    idx_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs_p1 && rxs_prev_p2) begin
          state_nxt = START;
          cnt_load  = 1'b1;
          cnt_val   = HALF_M1;
        end
      end
      START: begin
        if (expired) begin
          if (rxs_p1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_load  = 1'b1;
            idx_clr   = 1'b1;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          if (bit_idx == LAST_IX) state_nxt = STOP;
        end
      end
      STOP: begin
        if (expired) begin
          if (rxs_p1) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_p1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing counter, bit index and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (cnt_load)     cnt <= cnt_val;
      else if (!expired) cnt <= cnt - 1'b1;
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      frame_err <= stop_bad;
      overflow  <= fifo_drop;
    end
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rxs_p1, shreg[UART_DATA_BITS-1:1]};
  end

  hfrv_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (byte_done),
    .din   (shreg),
    .pop   (rx_ready),
    .dout  (rx_data),
    .valid (rx_valid),
    .drop  (fifo_drop),
    .count (fifo_count)
  );

endmodule
